// File: rtl/mipi_multilane_byte_aligner.sv
// rtl/mipi_multilane_byte_aligner.sv - multi-lane HS sync lock, deskew FIFOs and word-aligned output
module mipi_multilane_byte_aligner #(
    parameter int         LANES        = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hB8,
    parameter int         DESKEW_DEPTH = 4
) (
    input  logic               byte_clk,
    input  logic               sys_rst_n,
    input  logic               align_rst_n,
    input  logic [2:0]         lanes_active,
    input  logic [LANES*8-1:0] data_in,
    output logic [LANES-1:0]   lane_locked,
    output logic               data_out_valid,
    output logic               data_out_sop,
    output logic [LANES*8-1:0] data_out,
    output logic               deskew_err
);
    localparam int AW = $clog2(DESKEW_DEPTH);
    localparam int CW = $clog2(DESKEW_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DESKEW_DEPTH);

    logic               align_rst_n_d;
    logic               clr;
    logic [2:0]         n_active;
    logic [LANES-1:0]   active;
    logic [LANES-1:0]   fifo_nempty;
    logic [LANES-1:0]   fifo_full;
    logic [LANES-1:0]   lane_push_req;
    logic [LANES*8-1:0] head_word;
    logic               pop;
    logic               overflow;
    logic               sop_done;

    assign clr = ~align_rst_n_d;

    always_comb begin
        if (lanes_active == 3'd0) begin
            n_active = 3'd1;
        end else if (lanes_active > 3'(LANES)) begin
            n_active = 3'(LANES);
        end else begin
            n_active = lanes_active;
        end
    end

    // Inactive lanes count as "ready" so they never hold off the pop.
    assign pop      = (&(fifo_nempty | ~active)) & ~deskew_err;
    assign overflow = (|(lane_push_req & fifo_full)) & ~pop;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0]    prev_q;
        logic [7:0]    cur_q;
        logic [7:0]    byte_q;
        logic [2:0]    off_q;
        logic [2:0]    hit_k;
        logic [2:0]    sel_k;
        logic          hit;
        logic          locked_q;
        logic          vld_q;
        logic          push;
        logic          pop_l;
        logic [15:0]   win;
        logic [7:0]    mem [DESKEW_DEPTH];
        logic [AW-1:0] wr_ptr;
        logic [AW-1:0] rd_ptr;
        logic [CW-1:0] cnt;

        assign win = {cur_q, prev_q};

        // Descending scan so the lowest matching offset is the one kept.
        always_comb begin
            hit   = 1'b0;
            hit_k = 3'd0;
            for (int k = 7; k >= 0; k--) begin
                if (win[k +: 8] == SYNC_BYTE) begin
                    hit   = 1'b1;
                    hit_k = 3'(k);
                end
            end
        end

        assign sel_k            = locked_q ? off_q : hit_k;
        assign active[g]        = (3'(g) < n_active);
        assign lane_push_req[g] = vld_q & active[g];
        assign fifo_nempty[g]   = (cnt != '0);
        assign fifo_full[g]     = (cnt == FULL_CNT);
        assign push             = lane_push_req[g] & (~fifo_full[g] | pop) & ~clr;
        assign pop_l            = pop & active[g];
        assign lane_locked[g]   = locked_q;
        assign head_word[8*g +: 8] = active[g] ? mem[rd_ptr] : 8'h00;

        always_ff @(posedge byte_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                prev_q   <= 8'h00;
                cur_q    <= 8'h00;
                byte_q   <= 8'h00;
                off_q    <= 3'd0;
                locked_q <= 1'b0;
                vld_q    <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
            end else if (clr) begin
                prev_q   <= 8'h00;
                cur_q    <= 8'h00;
                byte_q   <= 8'h00;
                off_q    <= 3'd0;
                locked_q <= 1'b0;
                vld_q    <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
            end else begin
                prev_q <= cur_q;
                cur_q  <= data_in[8*g +: 8];
                if (!locked_q && hit) begin
                    locked_q <= 1'b1;
                    off_q    <= hit_k;
                end
                if (locked_q || hit) begin
                    byte_q <= win[sel_k +: 8];
                    vld_q  <= 1'b1;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_l) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop_l) begin
                    cnt <= cnt + CW'(1);
                end else if (!push && pop_l) begin
                    cnt <= cnt - CW'(1);
                end
            end
        end

        always_ff @(posedge byte_clk) begin
            if (push) begin
                mem[wr_ptr] <= byte_q;
            end
        end
    end

    always_ff @(posedge byte_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            align_rst_n_d  <= 1'b0;
            data_out_valid <= 1'b0;
            data_out_sop   <= 1'b0;
            data_out       <= '0;
            deskew_err     <= 1'b0;
            sop_done       <= 1'b0;
        end else begin
            align_rst_n_d <= align_rst_n;
            if (clr) begin
                data_out_valid <= 1'b0;
                data_out_sop   <= 1'b0;
                data_out       <= '0;
                deskew_err     <= 1'b0;
                sop_done       <= 1'b0;
            end else begin
                if (overflow) begin
                    deskew_err <= 1'b1;
                end
                if (pop) begin
                    data_out       <= head_word;
                    data_out_valid <= 1'b1;
                    data_out_sop   <= ~sop_done;
                    sop_done       <= 1'b1;
                end else begin
                    data_out_valid <= 1'b0;
                    data_out_sop   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mipi_multilane_byte_aligner.sv
// tb/tb_mipi_multilane_byte_aligner.sv - randomized bench with a bit-stream reference model
module tb_mipi_multilane_byte_aligner;
    localparam int L = 4;
    localparam int D = 4;
    localparam int N = 32;
    localparam logic [7:0] SYNC = 8'hB8;
    typedef logic [L+3+L*8-1:0] obs_t;

    logic           byte_clk = 1'b0;
    logic           sys_rst_n;
    logic           align_rst_n;
    logic [2:0]     lanes_active;
    logic [L*8-1:0] data_in;
    logic [L-1:0]   lane_locked;
    logic           data_out_valid;
    logic           data_out_sop;
    logic [L*8-1:0] data_out;
    logic           deskew_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] lane_bytes [L][N];
    int e0 [L];
    int spos [L];
    int n_eff;

    always #5 byte_clk = ~byte_clk;

    mipi_multilane_byte_aligner #(.LANES(L), .SYNC_BYTE(SYNC), .DESKEW_DEPTH(D)) dut (
        .byte_clk(byte_clk), .sys_rst_n(sys_rst_n), .align_rst_n(align_rst_n),
        .lanes_active(lanes_active), .data_in(data_in), .lane_locked(lane_locked),
        .data_out_valid(data_out_valid), .data_out_sop(data_out_sop),
        .data_out(data_out), .deskew_err(deskew_err)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Serial bit p of lane i (bit 0 of byte 0 first); bits before the burst read as 0.
    function automatic logic [7:0] sbyte(int i, int p);
        logic [7:0] r;
        logic [7:0] b;
        for (int j = 0; j < 8; j++) begin
            if (p + j < 0 || p + j >= 8 * N) begin
                r[j] = 1'b0;
            end else begin
                b = lane_bytes[i][(p + j) / 8];
                r[j] = b[(p + j) % 8];
            end
        end
        return r;
    endfunction

    function automatic void put_byte(int i, int p, logic [7:0] v);
        for (int j = 0; j < 8; j++) lane_bytes[i][(p + j) / 8][(p + j) % 8] = v[j];
    endfunction

    // A lane locks on the first serial position holding the sync pattern.
    function automatic void scan_lane(int i);
        e0[i] = -1;
        spos[i] = 0;
        for (int p = -7; p <= 8 * N - 8; p++) begin
            if (sbyte(i, p) == SYNC) begin
                spos[i] = p;
                e0[i] = (p + 8) / 8;
                return;
            end
        end
    endfunction

    function automatic obs_t model(int t);
        logic [L-1:0]   lk;
        logic [L*8-1:0] d;
        logic v, sop, err;
        int mx, mn;
        bit all_lk;
        mx = -1; mn = 1 << 30; all_lk = 1;
        lk = '0; d = '0; v = 0; sop = 0; err = 0;
        for (int i = 0; i < L; i++) lk[i] = (e0[i] >= 0) && (t >= e0[i] + 1);
        for (int i = 0; i < n_eff; i++) begin
            if (e0[i] < 0) all_lk = 0;
            else begin
                if (e0[i] > mx) mx = e0[i];
                if (e0[i] < mn) mn = e0[i];
            end
        end
        if (all_lk) begin
            if (mx - mn >= D) begin
                err = (t >= mn + D + 2);
            end else if (t >= mx + 3) begin
                v = 1;
                sop = (t == mx + 3);
                for (int i = 0; i < n_eff; i++) d[8*i +: 8] = sbyte(i, spos[i] + 8 * (t - mx - 3));
            end
        end
        return {lk, v, sop, err, d};
    endfunction

    function automatic obs_t observe();
        return {lane_locked, data_out_valid, data_out_sop, deskew_err, data_out};
    endfunction

    task automatic set_active(int la);
        lanes_active = 3'(la);
        n_eff = (la == 0) ? 1 : (la > L) ? L : la;
    endtask

    task automatic build_lane(int i, int c, int k, bit fixed_payload);
        int tries = 0;
        do begin
            for (int t = 0; t < N; t++) lane_bytes[i][t] = 8'($urandom);
            put_byte(i, 8 * c + k, SYNC);
            if (fixed_payload) begin
                put_byte(i, 8 * c + k + 8, 8'h11);
                put_byte(i, 8 * c + k + 16, 8'h22);
                put_byte(i, 8 * c + k + 24, 8'h33);
            end
            scan_lane(i);
            tries++;
        end while (spos[i] != 8 * c + k && tries < 200);
        checks++;
        if (spos[i] != 8 * c + k) begin
            failures++;
            $display("FAIL build_lane lane=%0d got_pos=%0d required_pos=%0d", i, spos[i], 8 * c + k);
        end
    endtask

    task automatic quiet_lane(int i);
        for (int t = 0; t < N; t++) lane_bytes[i][t] = 8'h00;
        scan_lane(i);
    endtask

    task automatic drive(int t);
        for (int i = 0; i < L; i++) data_in[8*i +: 8] = lane_bytes[i][t];
    endtask

    task automatic step();
        @(posedge byte_clk);
        #1;
    endtask

    task automatic pulse_align();
        align_rst_n = 1'b0;
        step();
        align_rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; align_rst_n = 1'b1; data_in = '0;
        set_active(4);
        repeat (3) step();
        checks++;
        if (observe() !== '0) begin
            failures++;
            $display("FAIL reset_hold got=%h required=0", observe());
        end
        sys_rst_n = 1'b1;
        step(); step();
        checks++;
        if (observe() !== '0) begin
            failures++;
            $display("FAIL reset_release got=%h required=0", observe());
        end
    endtask

    task automatic test_zero_skew();
        logic [31:0] lit [4];
        lit[0] = 32'hB8B8B8B8; lit[1] = 32'h11111111; lit[2] = 32'h22222222; lit[3] = 32'h33333333;
        set_active(4);
        for (int i = 0; i < L; i++) build_lane(i, 2, 3, 1);
        pulse_align();
        for (int t = 0; t < N; t++) begin
            drive(t);
            step();
            checks++;
            if (observe() !== model(t)) begin
                failures++;
                $display("FAIL zero_skew t=%0d got=%h required=%h", t, observe(), model(t));
            end
            if (t >= 6 && t <= 9) begin
                checks++;
                if ({data_out_valid, data_out_sop, data_out} !== {1'b1, t == 6, lit[t-6]}) begin
                    failures++;
                    $display("FAIL zero_skew_word t=%0d got=%h required=%h", t,
                             {data_out_valid, data_out_sop, data_out}, {1'b1, t == 6, lit[t-6]});
                end
            end
        end
    endtask

    task automatic test_skew_offsets();
        int sop_t = -1;
        set_active(4);
        build_lane(0, 2, 0, 0);
        build_lane(1, 3, 5, 0);
        build_lane(2, 4, 7, 0);
        build_lane(3, 5, 2, 0);
        pulse_align();
        for (int t = 0; t < N; t++) begin
            drive(t);
            step();
            if (data_out_sop === 1'b1) sop_t = t;
            checks++;
            if (observe() !== model(t)) begin
                failures++;
                $display("FAIL skew_offsets t=%0d got=%h required=%h", t, observe(), model(t));
            end
        end
        checks++;
        if (sop_t != 9 || deskew_err !== 1'b0) begin
            failures++;
            $display("FAIL skew_sop_time got_t=%0d err=%b required_t=9 err=0", sop_t, deskew_err);
        end
    endtask

    task automatic test_overflow();
        bit seen_valid = 0;
        set_active(4);
        for (int i = 0; i < 3; i++) build_lane(i, 2, $urandom_range(0, 7), 0);
        build_lane(3, 6, $urandom_range(0, 7), 0);
        pulse_align();
        for (int t = 0; t < N; t++) begin
            drive(t);
            step();
            if (data_out_valid === 1'b1) seen_valid = 1;
            checks++;
            if (observe() !== model(t)) begin
                failures++;
                $display("FAIL overflow t=%0d got=%h required=%h", t, observe(), model(t));
            end
        end
        checks++;
        if (seen_valid || deskew_err !== 1'b1) begin
            failures++;
            $display("FAIL overflow_flag got_err=%b valid_seen=%0d required err=1 valid_seen=0", deskew_err, seen_valid);
        end
        align_rst_n = 1'b0;
        step();
        checks++;
        if ({deskew_err, lane_locked} !== {1'b1, 4'hF}) begin
            failures++;
            $display("FAIL overflow_hold got=%b_%b required=1_1111", deskew_err, lane_locked);
        end
        align_rst_n = 1'b1;
        step();
        checks++;
        if ({deskew_err, lane_locked} !== 5'b0) begin
            failures++;
            $display("FAIL overflow_clear got=%b_%b required=0_0000", deskew_err, lane_locked);
        end
    endtask

    task automatic test_partial_lanes();
        set_active(2);
        build_lane(0, 2, $urandom_range(0, 7), 0);
        build_lane(1, 3, $urandom_range(0, 7), 0);
        quiet_lane(2);
        quiet_lane(3);
        pulse_align();
        for (int t = 0; t < N; t++) begin
            drive(t);
            step();
            checks++;
            if (observe() !== model(t) || data_out[31:16] !== 16'h0) begin
                failures++;
                $display("FAIL partial2 t=%0d got=%h required=%h", t, observe(), model(t));
            end
        end
        set_active(0);
        build_lane(0, 3, $urandom_range(0, 7), 0);
        build_lane(1, 2, $urandom_range(0, 7), 0);
        pulse_align();
        for (int t = 0; t < N; t++) begin
            drive(t);
            step();
            checks++;
            if (observe() !== model(t)) begin
                failures++;
                $display("FAIL partial0 t=%0d got=%h required=%h", t, observe(), model(t));
            end
        end
    endtask

    task automatic test_realign();
        set_active(4);
        for (int i = 0; i < L; i++) build_lane(i, 2, 2, 0);
        pulse_align();
        for (int t = 0; t < 12; t++) begin
            drive(t);
            step();
            checks++;
            if (observe() !== model(t)) begin
                failures++;
                $display("FAIL realign_first t=%0d got=%h required=%h", t, observe(), model(t));
            end
        end
        align_rst_n = 1'b0;
        step();
        align_rst_n = 1'b1;
        step();
        checks++;
        if ({data_out_valid, lane_locked} !== 5'b0) begin
            failures++;
            $display("FAIL realign_drop got=%b_%b required=0_0000", data_out_valid, lane_locked);
        end
        for (int i = 0; i < L; i++) build_lane(i, 2, 6, 0);
        for (int t = 0; t < N; t++) begin
            drive(t);
            step();
            checks++;
            if (observe() !== model(t)) begin
                failures++;
                $display("FAIL realign_second t=%0d got=%h required=%h", t, observe(), model(t));
            end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            set_active($urandom_range(0, 7));
            for (int i = 0; i < L; i++) build_lane(i, 2 + $urandom_range(0, 4), $urandom_range(0, 7), 0);
            pulse_align();
            for (int t = 0; t < N; t++) begin
                drive(t);
                step();
                checks++;
                if (observe() !== model(t)) begin
                    failures++;
                    $display("FAIL random b=%0d t=%0d got=%h required=%h", b, t, observe(), model(t));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        set_active(4);
        for (int i = 0; i < L; i++) build_lane(i, 2, 1, 0);
        pulse_align();
        for (int t = 0; t < 10; t++) begin
            drive(t);
            step();
        end
        checks++;
        if (data_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL async_pre got_valid=%b required=1", data_out_valid);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (observe() !== '0) begin
            failures++;
            $display("FAIL async_assert got=%h required=0", observe());
        end
        #3 sys_rst_n = 1'b1;
        for (int t = 10; t < 15; t++) begin
            drive(t);
            step();
            checks++;
            if ({data_out_valid, data_out_sop} !== 2'b00) begin
                failures++;
                $display("FAIL async_release t=%0d got=%b required=00", t, {data_out_valid, data_out_sop});
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_skew();
        test_skew_offsets();
        test_overflow();
        test_partial_lanes();
        test_realign();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mipi_multilane_byte_aligner.md
Name: mipi_multilane_byte_aligner

Overview:
Parametrised successor to the single-lane HS byte aligner, placed between the per-lane deserialisers and the DSI packet parser.
- Each lane locks to the HS sync byte at any of 8 bit offsets.
- Lanes are deskewed through per-lane FIFOs.
- Output is one word-aligned multi-lane word per byte_clk, with start-of-burst flag, per-lane lock status and a sticky deskew-overflow error.

Parameters:
LANES, 4, number of physical lanes (1..4)
SYNC_BYTE, 8'hB8, sync pattern as the aligned byte value in LSB-first order (first serial bit = bit 0)
DESKEW_DEPTH, 4, per-lane FIFO depth in bytes (power of 2, 2..16); tolerated inter-lane skew is DESKEW_DEPTH-1 cycles

Ports:
byte_clk  in  1  byte clock, all lanes share it
sys_rst_n  in  1  asynchronous, active-low reset
align_rst_n  in  1  active-low burst restart, synchronous; internally registered once (align_rst_n_d)
lanes_active  in  3  number of lanes in use; 0 is treated as 1, values above LANES are clamped to LANES; held stable during a burst
data_in  in  LANES*8  raw deserialised bytes, lane i at [8i+7:8i], bit 0 received first
lane_locked  out  LANES  per-lane sync-found status
data_out_valid  out  1  data_out holds an aligned, deskewed word
data_out_sop  out  1  high with the first valid word of a burst (all sync bytes)
data_out  out  LANES*8  aligned word, lane 0 in the low byte; inactive lanes read 0
deskew_err  out  1  sticky: a lane FIFO overflowed

Behaviour:
- Reset: sys_rst_n low asynchronously clears all state. All outputs become 0.
- align_rst_n_d low has the same effect as reset, synchronously, for all state except align_rst_n_d itself.
- Per-lane window:
  - On each edge (E0): prev<=cur, cur<=data_in lane byte.
  - The 16-bit window is w={cur,prev}; prev is older and sits in the low bits. Candidate at offset k (0..7) is w[k+7:k].
- Lock search:
  - While unlocked, the lowest k with a candidate equal to SYNC_BYTE wins.
  - At E1: offset<=k, lane_locked[i]<=1, lane byte register<=candidate (equal to SYNC_BYTE), lane_vld<=1.
- While locked:
  - The lane byte register loads w[offset+7:offset] every cycle with lane_vld=1.
  - The offset is frozen; later sync-like patterns are ignored until align_rst_n_d is low or reset.
- Lanes with index >= lanes_active:
  - They may lock (lane_locked still reports).
  - They are excluded from pop, error and output, and their data_out bytes are 0.
- Deskew FIFO per lane:
  - Pushes the lane byte register when lane_vld=1 (first push at E2 = the sync byte).
  - Pops occur when every active lane FIFO is non-empty and deskew_err=0; all active FIFOs pop together.
  - The popped heads are registered into data_out at the same edge, with data_out_valid<=1.
  - data_out_sop<=1 for the first pop after align reset only.
  - A simultaneous push and pop leaves the count unchanged.
- Latency: data_out_sop rises 3 edges after the E0 at which the last active lane's sync completes in its window. Valid stays high continuously thereafter.
- Overflow: a push into a full active FIFO sets deskew_err at that edge. Then:
  - data_out_valid<=0 and pops stop.
  - deskew_err holds until align_rst_n_d is low or reset.
  - Inter-lane skew s <= DESKEW_DEPTH-1 is accepted; s = DESKEW_DEPTH triggers the error.
- Before all active lanes lock: data_out_valid=0, data_out=0, data_out_sop=0.
- Simultaneous lock: lanes locking on the same edge behave as zero skew.
- Mid-burst align_rst_n: lanes relock on the next sync with a possibly different offset; FIFOs are emptied.

Test Plan:
1. LANES=4, lanes_active=4, zero skew, every lane offset 3, payload 11,22,33 after sync -> 3 edges after the sync E0, data_out=B8B8B8B8 with sop=1. Then 11111111, 22222222, 33333333 on consecutive cycles, sop=0.
2. Offsets 0/5/7/2 on lanes 0..3, lane skews 0/1/2/3 cycles, DESKEW_DEPTH=4 -> sop 3 edges after lane 3's sync E0, words aligned per lane, deskew_err=0.
3. Skew of 4 cycles on lane 3, DESKEW_DEPTH=4 -> deskew_err=1, data_out_valid never 1. An align_rst_n low pulse clears deskew_err and lane_locked one edge after it is registered.
4. lanes_active=2, lanes 2/3 carry no sync -> sop 3 edges after lanes 0/1 lock, data_out[31:16]=0. lanes_active=0 behaves as 1.
5. Lock at offset 2, then align_rst_n pulsed mid-burst, then new sync at offset 6 -> valid drops and lane_locked clears, relock at offset 6, new sop with B8 bytes.
6. sys_rst_n asserted asynchronously mid-stream -> all outputs 0 immediately, no glitch of valid on release.
